store_lane_unit: RTL and testbench
==================================

Name: store_lane_unit

Overview:
- Store-side counterpart of the load-path sign/zero extension: narrows a 32-bit register value to byte/half/word and places it on the correct byte lanes with byte enables.
- Sits between the MEM-stage store issue and the data memory port.
- Buffers stores in a small in-order FIFO and drains them to memory over a req/ack handshake.

Parameters:
DEPTH, 4, store buffer entries (power of two, >=2)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
stValid  input  1  store request valid
stReady  output  1  unit can accept a store this cycle
stAddr  input  32  byte address of store
stData  input  32  register value; low bits used for byte/half
stSize  input  2  00 byte, 01 half, 10 word, 11 reserved
memReq  output  1  memory write request
memAddr  output  32  word-aligned write address
memWData  output  32  lane-positioned write data
memBe  output  4  byte enables, bit i = byte lane i (little-endian)
memAck  input  1  memory accepted current request
bufCount  output  clog2(DEPTH+1)  occupied entries
bufEmpty  output  1  bufCount == 0
misalign  output  1  one-cycle pulse: illegal/misaligned store dropped

Behaviour:
- Reset: memReq=0, memAddr=0, memWData=0, memBe=0, bufCount=0, bufEmpty=1, misalign=0, FSM=IDLE, FIFO pointers 0. stReady=0 while rst=1.
- Accept: handshake when stValid && stReady. stReady = !rst && (bufCount < DEPTH). No accept while full, even if a pop occurs that cycle.
- Lane placement (combinational at accept, stored in entry):
  - byte: wdata = {4{stData[7:0]}}, be = 4'b0001 << stAddr[1:0]
  - half: wdata = {2{stData[15:0]}}, be = stAddr[1] ? 4'b1100 : 4'b0011
  - word: wdata = stData, be = 4'b1111
  - entry addr = {stAddr[31:2], 2'b00}
- FIFO: strict in-order. Simultaneous accept and pop leaves bufCount unchanged. Pointers wrap modulo DEPTH.
- FSM IDLE/REQ:
  - IDLE: if bufCount>0, latch head into memAddr/memWData/memBe and go to REQ.
  - REQ: memReq=1. Outputs held stable until memAck. On memAck, pop head and return to IDLE. memReq drops for at least one cycle between requests.
- memAck outside REQ is ignored.
- Latency: store accepted in cycle N into an empty, idle unit gives memReq=1 in cycle N+2.
- Reset mid-operation: buffered and in-flight stores are discarded. memReq=0 the cycle after rst is sampled.
- bufCount/bufEmpty are registered and reflect completed edges.

Optional Feature:
MISALIGN_EXC_EN
- Defined:
  - half with stAddr[0]=1, word with stAddr[1:0]!=0, or stSize=11 is accepted but not enqueued.
  - misalign=1 for exactly the cycle after the accept.
- Undefined:
  - misalign is tied 0.
  - Unused low address bits are ignored (half uses only stAddr[1], word ignores stAddr[1:0]).
  - stSize=11 is treated as word.

Test Plan:
- Reset, then sb addr 0x1003 data 0x000000A5, memAck one cycle after memReq: memReq at N+2, memAddr 0x1000, memWData 0xA5A5A5A5, memBe 0001→1000? No: memBe=4'b1000.
- sh addr 0x2002 data 0x1234BEEF: memWData 0xBEEFBEEF, memBe 4'b1100. Then sw addr 0x2004 data 0xCAFEF00D: memBe 4'b1111, issued in order.
- memAck held 0, push 5 words: stReady=0 after 4 accepts, bufCount=4. Release ack: drains in order, bufCount→0, bufEmpty=1.
- Accept coinciding with memAck pop at bufCount=2: bufCount stays 2.
- Assert rst mid-REQ with 3 entries: next cycle memReq=0, bufCount=0. No stale entries issue after release.
- With MISALIGN_EXC_EN, sw addr 0x3002: misalign pulses 1 cycle, nothing enqueued. Without it: memAddr 0x3000, memBe 1111, misalign=0.

Source files
------------

// File: rtl/store_lane_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_lane_unit
// Purpose  : Narrows store data to byte/half/word, places it on its byte lanes
//            and drains it to data memory through a small in-order buffer.
// Options  : MISALIGN_EXC_EN - drop misaligned/reserved stores, pulse misalign
// Revision : 1.0 - initial release
// ============================================================================
module store_lane_unit #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stValid,
    output logic                       stReady,
    input  logic [31:0]                stAddr,
    input  logic [31:0]                stData,
    input  logic [1:0]                 stSize,
    output logic                       memReq,
    output logic [31:0]                memAddr,
    output logic [31:0]                memWData,
    output logic [3:0]                 memBe,
    input  logic                       memAck,
    output logic [$clog2(DEPTH+1)-1:0] bufCount,
    output logic                       bufEmpty,
    output logic                       misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic [29:0]   r_buf_addr  [DEPTH];
    logic [31:0]   r_buf_wdata [DEPTH];
    logic [3:0]    r_buf_be    [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;

    logic          w_accept;
    logic          w_enq;
    logic          w_pop;
    logic          w_latch;
    logic          w_illegal;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic [CW-1:0] w_count_next;

    // ------------------------------------------------------------------
    // Accept handshake: a full buffer refuses even if a pop is in flight
    // ------------------------------------------------------------------
    assign stReady  = !rst && (r_count < c_depth);
    assign w_accept = stValid && stReady;
    assign w_enq    = w_accept && !w_illegal;

    // ------------------------------------------------------------------
    // Lane placement
    // ------------------------------------------------------------------
    always_comb begin
        w_wdata = stData;
        w_be    = 4'b1111;
        case (stSize)
            c_size_byte: begin
                w_wdata = {4{stData[7:0]}};
                w_be    = 4'b0001 << stAddr[1:0];
            end
            c_size_half: begin
                w_wdata = {2{stData[15:0]}};
                w_be    = stAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = stData;
                w_be    = 4'b1111;
            end
        endcase
    end

`ifdef MISALIGN_EXC_EN
    always_comb begin
        w_illegal = 1'b0;
        case (stSize)
            c_size_half: w_illegal = stAddr[0];
            c_size_word: w_illegal = (stAddr[1:0] != 2'b00);
            c_size_byte: w_illegal = 1'b0;
            default:     w_illegal = 1'b1;
        endcase
    end

    logic r_misalign;

    // Dropped stores are still accepted, so the pulse follows the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_accept && w_illegal;
        end
    end

    assign misalign = r_misalign;
`else
    assign w_illegal = 1'b0;
    assign misalign  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Buffer storage (no reset needed: validity is tracked by the count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_buf_addr[r_wr_ptr]  <= stAddr[31:2];
            r_buf_wdata[r_wr_ptr] <= w_wdata;
            r_buf_be[r_wr_ptr]    <= w_be;
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_enq, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The head stays in the buffer until acknowledged, so REQ always has one
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_latch      = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (memAck) begin
                    w_pop        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else if (w_latch) begin
            r_mem_addr  <= {r_buf_addr[r_rd_ptr], 2'b00};
            r_mem_wdata <= r_buf_wdata[r_rd_ptr];
            r_mem_be    <= r_buf_be[r_rd_ptr];
        end
    end

    assign memReq   = (r_state == S_REQ);
    assign memAddr  = r_mem_addr;
    assign memWData = r_mem_wdata;
    assign memBe    = r_mem_be;
    assign bufCount = r_count;
    assign bufEmpty = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_store_lane_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_lane_unit
// Purpose  : Self-checking bench for store_lane_unit (vector table + scoreboard)
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_lane_unit;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          stValid;
    logic          stReady;
    logic [31:0]   stAddr;
    logic [31:0]   stData;
    logic [1:0]    stSize;
    logic          memReq;
    logic [31:0]   memAddr;
    logic [31:0]   memWData;
    logic [3:0]    memBe;
    logic          memAck;
    logic [CW-1:0] bufCount;
    logic          bufEmpty;
    logic          misalign;

    logic resp_ack;
    logic manual_ack;
    assign memAck = resp_ack | manual_ack;

    store_lane_unit #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .stValid  (stValid),
        .stReady  (stReady),
        .stAddr   (stAddr),
        .stData   (stData),
        .stSize   (stSize),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memBe    (memBe),
        .memAck   (memAck),
        .bufCount (bufCount),
        .bufEmpty (bufEmpty),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   ack_en   = 1'b0;
    bit   seen     = 1'b0;
    exp_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b);
        exp_t e;
        e.addr  = a;
        e.wdata = w;
        e.be    = b;
        return e;
    endfunction

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_unexpected_req"}, 32'(memReq), 32'd0);
        end else begin
            e = sb_q.pop_front();
            cur = e;
            chk({tag, "_addr"},  memAddr,        e.addr);
            chk({tag, "_wdata"}, memWData,       e.wdata);
            chk({tag, "_be"},    32'(memBe),     32'(e.be));
        end
    endtask

    // Memory model: sees the request, checks it, acknowledges one cycle later
    initial begin
        resp_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!ack_en) begin
                seen     = 1'b0;
                resp_ack = 1'b0;
            end else if (memReq) begin
                if (!seen) begin
                    compare_head("issue");
                    seen = 1'b1;
                end else begin
                    chk("hold_addr",  memAddr,  cur.addr);
                    chk("hold_wdata", memWData, cur.wdata);
                    resp_ack = 1'b1;
                end
            end else begin
                resp_ack = 1'b0;
                seen     = 1'b0;
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int i;
        @(negedge clk);
        stValid = 1'b1;
        stAddr  = a;
        stData  = d;
        stSize  = s;
        i = 0;
        while (!stReady && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!stReady) chk("store_ready_timeout", 32'(stReady), 32'd1);
        @(posedge clk);
        #1 stValid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bufEmpty && !memReq && sb_q.size() == 0) break;
        end
        chk({tag, "_count"}, 32'(bufCount), 32'd0);
        chk({tag, "_empty"}, 32'(bufEmpty), 32'd1);
        chk({tag, "_sb"},    32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_req(input string tag);
        int i;
        i = 0;
        while (!memReq && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!memReq) chk({tag, "_req_timeout"}, 32'(memReq), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vec_t vt[6];
    bit   saw_req;

    initial begin
        vt[0] = '{32'h0000_1003, 32'h0000_00A5, 2'b00, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000};
        vt[1] = '{32'h0000_2002, 32'h1234_BEEF, 2'b01, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
        vt[2] = '{32'h0000_2004, 32'hCAFE_F00D, 2'b10, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111};
        vt[3] = '{32'h0000_0010, 32'h1111_117E, 2'b00, 32'h0000_0010, 32'h7E7E_7E7E, 4'b0001};
        vt[4] = '{32'h0000_0011, 32'h2222_2233, 2'b00, 32'h0000_0010, 32'h3333_3333, 4'b0010};
        vt[5] = '{32'hFFFF_FFC0, 32'h5555_ABCD, 2'b01, 32'hFFFF_FFC0, 32'hABCD_ABCD, 4'b0011};

        rst = 1'b1; stValid = 1'b0; stAddr = '0; stData = '0; stSize = '0;
        manual_ack = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memReq",   32'(memReq),   32'd0);
        chk("rst_memAddr",  memAddr,       32'd0);
        chk("rst_memWData", memWData,      32'd0);
        chk("rst_memBe",    32'(memBe),    32'd0);
        chk("rst_bufCount", 32'(bufCount), 32'd0);
        chk("rst_bufEmpty", 32'(bufEmpty), 32'd1);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_stReady",  32'(stReady),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stReady", 32'(stReady), 32'd1);

        // Accept-to-request latency
        ack_en = 1'b1;
        @(negedge clk);
        stValid = 1'b1; stAddr = 32'h0000_1003; stData = 32'h0000_00A5; stSize = 2'b00;
        chk("lat_ready", 32'(stReady), 32'd1);
        @(posedge clk);
        #1 stValid = 1'b0;
        sb_q.push_back(mk(32'h0000_1000, 32'hA5A5_A5A5, 4'b1000));
        @(negedge clk);
        chk("lat_n1_req",   32'(memReq),   32'd0);
        chk("lat_n1_count", 32'(bufCount), 32'd1);
        @(negedge clk);
        chk("lat_n2_req",   32'(memReq),   32'd1);
        wait_drain("lat");

        // Lane placement table, issued back to back
        for (int i = 0; i < 6; i++) begin
            do_store(vt[i].addr, vt[i].data, vt[i].size);
            sb_q.push_back(mk(vt[i].exp_addr, vt[i].exp_wdata, vt[i].exp_be));
        end
        wait_drain("table");

        // Fill with acks held off
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h0000_5000 + 32'(i * 4), 32'hD000_0000 + 32'(i), 2'b10);
            sb_q.push_back(mk(32'h0000_5000 + 32'(i * 4), 32'hD000_0000 + 32'(i), 4'b1111));
        end
        @(negedge clk);
        chk("full_ready", 32'(stReady),  32'd0);
        chk("full_count", 32'(bufCount), 32'd4);
        chk("full_req",   32'(memReq),   32'd1);
        ack_en = 1'b1;
        do_store(32'h0000_5010, 32'hD000_0004, 2'b10);
        sb_q.push_back(mk(32'h0000_5010, 32'hD000_0004, 4'b1111));
        wait_drain("full");

        // Accept coinciding with a pop leaves the count unchanged
        ack_en = 1'b0;
        do_store(32'h0000_6000, 32'h6000_0000, 2'b10);
        sb_q.push_back(mk(32'h0000_6000, 32'h6000_0000, 4'b1111));
        do_store(32'h0000_6004, 32'h6000_0004, 2'b10);
        sb_q.push_back(mk(32'h0000_6004, 32'h6000_0004, 4'b1111));
        @(negedge clk);
        wait_req("coinc");
        chk("coinc_pre_count", 32'(bufCount), 32'd2);
        compare_head("coinc");
        manual_ack = 1'b1;
        stValid = 1'b1; stAddr = 32'h0000_6009; stData = 32'h0000_0077; stSize = 2'b00;
        chk("coinc_ready", 32'(stReady), 32'd1);
        @(posedge clk);
        #1;
        manual_ack = 1'b0;
        stValid = 1'b0;
        sb_q.push_back(mk(32'h0000_6008, 32'h7777_7777, 4'b0010));
        @(negedge clk);
        chk("coinc_count", 32'(bufCount), 32'd2);
        ack_en = 1'b1;
        wait_drain("coinc");

        // Reset while a request is outstanding
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_store(32'h0000_7000 + 32'(i * 4), 32'h7000_0000 + 32'(i), 2'b10);
            sb_q.push_back(mk(32'h0000_7000 + 32'(i * 4), 32'h7000_0000 + 32'(i), 4'b1111));
        end
        @(negedge clk);
        wait_req("midrst");
        chk("midrst_pre_count", 32'(bufCount), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req",   32'(memReq),   32'd0);
        chk("midrst_count", 32'(bufCount), 32'd0);
        chk("midrst_empty", 32'(bufEmpty), 32'd1);
        chk("midrst_ready", 32'(stReady),  32'd0);
        sb_q.delete();
        rst = 1'b0;
        saw_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (memReq) saw_req = 1'b1;
        end
        chk("midrst_no_stale", 32'(saw_req), 32'd0);
        ack_en = 1'b1;

        // Misaligned word store
        do_store(32'h0000_3002, 32'h1122_3344, 2'b10);
`ifdef MISALIGN_EXC_EN
        @(negedge clk);
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_count", 32'(bufCount), 32'd0);
        @(negedge clk);
        chk("mis_pulse_end", 32'(misalign), 32'd0);
        do_store(32'h0000_3001, 32'h0000_BEEF, 2'b01);
        @(negedge clk);
        chk("mis_half_pulse", 32'(misalign), 32'd1);
        wait_drain("mis");
`else
        sb_q.push_back(mk(32'h0000_3000, 32'h1122_3344, 4'b1111));
        @(negedge clk);
        chk("mis_none", 32'(misalign), 32'd0);
        wait_drain("mis");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
